// File: rtl/ring_phase_monitor.sv
// Consumer of the one-hot ring counter: encodes the hot bit to a phase index,
// checks legality and rotation direction, counts revolutions and faults.
module ring_phase_monitor #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDX_W = 2,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ERR_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             chk_en,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             clr_err,
    output logic [IDX_W-1:0] phase_idx,
    output logic             locked,
    output logic [CNT_W-1:0] rev_cnt,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ring_q, ring_d;
    logic [IDX_W-1:0] phase_idx_q, phase_idx_d;
    logic             locked_q, locked_d;
    logic [CNT_W-1:0] rev_cnt_q, rev_cnt_d;
    logic             err_flag_q, err_flag_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             legal_c;
    logic [IDX_W-1:0] idx_c;
    logic [IDX_W-1:0] exp_c;
    logic             fault_c;

    // Sample decode: exactly one bit set, and where it sits
    always_comb begin
        legal_c = (ring_q != '0) && ((ring_q & (ring_q - WIDTH'(1))) == '0);
        idx_c   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (ring_q[i]) begin
                idx_c = IDX_W'(i);
            end
        end
        exp_c = (phase_idx_q == '0) ? IDX_W'(WIDTH - 1) : (phase_idx_q - IDX_W'(1));
    end

    always_comb begin
        ring_d      = ring_in;
        state_d     = state_q;
        phase_idx_d = phase_idx_q;
        locked_d    = locked_q;
        rev_cnt_d   = rev_cnt_q;
        err_flag_d  = err_flag_q;
        err_cnt_d   = err_cnt_q;
        fault_c     = 1'b0;

        if (!chk_en) begin
            state_d  = ST_ACQUIRE;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                ST_ACQUIRE: begin
                    if (legal_c) begin
                        phase_idx_d = idx_c;
                        locked_d    = 1'b1;
                        state_d     = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (legal_c && (idx_c == exp_c)) begin
                        phase_idx_d = idx_c;
                        // A revolution completes on the 1 -> 0 step
                        if ((phase_idx_q == IDX_W'(1)) && (idx_c == '0)) begin
                            rev_cnt_d = rev_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        fault_c  = 1'b1;
                        locked_d = 1'b0;
                        state_d  = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    locked_d = 1'b0;
                    if (clr_err) begin
                        state_d = ST_ACQUIRE;
                    end
                end
                default: begin
                    state_d  = ST_ACQUIRE;
                    locked_d = 1'b0;
                end
            endcase
        end

        // Clear first so a fault detected in the same cycle wins
        if (clr_err) begin
            err_flag_d = 1'b0;
            err_cnt_d  = '0;
        end
        if (fault_c) begin
            err_flag_d = 1'b1;
            if (clr_err) begin
                err_cnt_d = ERR_W'(1);
            end else if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_ACQUIRE;
            ring_q      <= '0;
            phase_idx_q <= '0;
            locked_q    <= 1'b0;
            rev_cnt_q   <= '0;
            err_flag_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ring_q      <= ring_d;
            phase_idx_q <= phase_idx_d;
            locked_q    <= locked_d;
            rev_cnt_q   <= rev_cnt_d;
            err_flag_q  <= err_flag_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign phase_idx = phase_idx_q;
    assign locked    = locked_q;
    assign rev_cnt   = rev_cnt_q;
    assign err_flag  = err_flag_q;
    assign err_cnt   = err_cnt_q;

endmodule
